// File: rtl/ram_burst_ctrl_if.sv
// ----------------------------------------------------------------------------
// ram_burst_ctrl_if
// Bundles the burst command, the write/read beat streams and the RAM pins of
// the burst controller.
//   slave  : the controller side (ram_burst_ctrl).
//   master : the user side, i.e. the command/data source together with the
//            RAM that sits downstream (it drives ram_dout back).
// Signals:
//   req/rw/start_addr/burst_len/ack  burst command handshake
//   wdata/wvalid/wready              write beat stream
//   rdata/rvalid                     read beat stream (no backpressure)
//   busy/done                        burst status
//   ram_cen/ram_wen/ram_addr/ram_din RAM control pins (registered)
//   ram_dout                         RAM registered read data
// ----------------------------------------------------------------------------
interface ram_burst_ctrl_if #(
   parameter int AW = 8,
   parameter int DW = 64
);
   logic          req;
   logic          rw;
   logic [AW-1:0] start_addr;
   logic [AW-1:0] burst_len;
   logic          ack;
   logic [DW-1:0] wdata;
   logic          wvalid;
   logic          wready;
   logic [DW-1:0] rdata;
   logic          rvalid;
   logic          busy;
   logic          done;
   logic          ram_cen;
   logic          ram_wen;
   logic [AW-1:0] ram_addr;
   logic [DW-1:0] ram_din;
   logic [DW-1:0] ram_dout;

   modport slave (
      input  req, rw, start_addr, burst_len, wdata, wvalid, ram_dout,
      output ack, wready, rdata, rvalid, busy, done,
             ram_cen, ram_wen, ram_addr, ram_din
   );

   modport master (
      output req, rw, start_addr, burst_len, wdata, wvalid, ram_dout,
      input  ack, wready, rdata, rvalid, busy, done,
             ram_cen, ram_wen, ram_addr, ram_din
   );
endinterface

// File: rtl/ram_burst_ctrl.sv
// ----------------------------------------------------------------------------
// ram_burst_ctrl
// Burst access controller in front of a 2^AW x DW single-port synchronous RAM
// whose dout is registered and cleared while cen is low.
// One command (start address, beats-minus-one, direction) is taken through
// req/ack; write beats stream in on wvalid/wready and are written through
// registered RAM pins one cycle after the handshake; reads are issued one per
// cycle and returned on rdata/rvalid two cycles after they appear on the pins.
// Ports:
//   clk      rising-edge clock shared with the RAM
//   reset_n  asynchronous active-low reset (aborts any burst, no done pulse)
//   bus      ram_burst_ctrl_if.slave (command, beat streams, RAM pins)
// ----------------------------------------------------------------------------
module ram_burst_ctrl #(
   parameter int AW = 8,
   parameter int DW = 64
) (
   input  logic            clk,
   input  logic            reset_n,
   ram_burst_ctrl_if.slave bus
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_WR,
      S_RD,
      S_RD_TAIL,
      S_FIN
   } state_t;

   state_t        r_state;
   logic [AW-1:0] r_addr;      // next beat address, wraps modulo 2^AW
   logic [AW-1:0] r_cnt;       // beats remaining minus one
   logic          r_tail;      // second RD_TAIL cycle marker
   logic          r_ack;
   logic          r_busy;
   logic          r_done;
   logic          r_ram_cen;
   logic          r_ram_wen;
   logic [AW-1:0] r_ram_addr;
   logic [DW-1:0] r_ram_din;

   // Read return pipeline
   logic          r_rd_pend;   // RAM dout holds a requested word this cycle
   logic          r_rvalid;
   logic [DW-1:0] r_rdata;
   logic          w_rd_issue;

   // ------------------------------------------------------------------------
   // Control FSM with registered outputs. The burst direction is carried by
   // the state itself (WR vs RD), so rw needs no separate holding register.
   // ------------------------------------------------------------------------
   // NOTE: every register here is assigned with <= so all of them update
   // together on the edge; blocking = would let later lines see new values.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state    <= S_IDLE;
         r_addr     <= '0;
         r_cnt      <= '0;
         r_tail     <= 1'b0;
         r_ack      <= 1'b0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_ram_cen  <= 1'b0;
         r_ram_wen  <= 1'b0;
         r_ram_addr <= '0;
         r_ram_din  <= '0;
      end else begin
         // Pulses default low; a state raises them for exactly one cycle
         r_ack  <= 1'b0;
         r_done <= 1'b0;

         case (r_state)
            S_IDLE: begin
               r_ram_cen <= 1'b0;
               r_ram_wen <= 1'b0;
               if (bus.req) begin
                  r_addr  <= bus.start_addr;
                  r_cnt   <= bus.burst_len;
                  r_ack   <= 1'b1;
                  r_busy  <= 1'b1;
                  r_state <= bus.rw ? S_WR : S_RD;
               end
            end

            S_WR: begin
               if (bus.wvalid) begin
                  // Beat accepted now, committed by the RAM on the next edge
                  r_ram_cen  <= 1'b1;
                  r_ram_wen  <= 1'b1;
                  r_ram_addr <= r_addr;
                  r_ram_din  <= bus.wdata;
                  r_addr     <= r_addr + AW'(1);
                  r_cnt      <= r_cnt - AW'(1);
                  if (r_cnt == '0) begin
                     r_state <= S_FIN;
                     r_done  <= 1'b1;
                  end
               end else begin
                  r_ram_cen <= 1'b0;
                  r_ram_wen <= 1'b0;
               end
            end

            S_RD: begin
               r_ram_cen  <= 1'b1;
               r_ram_wen  <= 1'b0;
               r_ram_addr <= r_addr;
               r_addr     <= r_addr + AW'(1);
               r_cnt      <= r_cnt - AW'(1);
               if (r_cnt == '0) begin
                  r_state <= S_RD_TAIL;
                  r_tail  <= 1'b0;
               end
            end

            // Two cycles let the last read drain through RAM dout and rdata,
            // so done lines up with the final rvalid.
            S_RD_TAIL: begin
               r_ram_cen <= 1'b0;
               r_ram_wen <= 1'b0;
               if (r_tail) begin
                  r_state <= S_FIN;
                  r_done  <= 1'b1;
               end else begin
                  r_tail <= 1'b1;
               end
            end

            S_FIN: begin
               r_ram_cen <= 1'b0;
               r_ram_wen <= 1'b0;
               r_busy    <= 1'b0;
               r_state   <= S_IDLE;
            end

            default: begin
               r_ram_cen <= 1'b0;
               r_ram_wen <= 1'b0;
               r_busy    <= 1'b0;
               r_state   <= S_IDLE;
            end
         endcase
      end
   end

   // ------------------------------------------------------------------------
   // Read return: a read on the pins in cycle n shows on RAM dout in n+1 and
   // is registered onto rdata/rvalid for cycle n+2. rdata holds otherwise,
   // because the RAM zeroes dout whenever cen is low.
   // ------------------------------------------------------------------------
   assign w_rd_issue = r_ram_cen & ~r_ram_wen;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_rd_pend <= 1'b0;
         r_rvalid  <= 1'b0;
         r_rdata   <= '0;
      end else begin
         r_rd_pend <= w_rd_issue;
         r_rvalid  <= r_rd_pend;
         if (r_rd_pend) begin
            r_rdata <= bus.ram_dout;
         end
      end
   end

   // NOTE: wready is a continuous assign of a state compare; decoding it in
   // an always block without a full default would infer a latch.
   assign bus.wready   = (r_state == S_WR);
   assign bus.ack      = r_ack;
   assign bus.busy     = r_busy;
   assign bus.done     = r_done;
   assign bus.rvalid   = r_rvalid;
   assign bus.rdata    = r_rdata;
   assign bus.ram_cen  = r_ram_cen;
   assign bus.ram_wen  = r_ram_wen;
   assign bus.ram_addr = r_ram_addr;
   assign bus.ram_din  = r_ram_din;

endmodule
